bus_burst_sram_slave: RTL and testbench
=======================================

Name: bus_burst_sram_slave

Overview:
- Word-organised on-chip SRAM that acts as a bus responder on the shared burst bus.
- Serves single and burst reads and writes from any bus master, e.g. the SPM DMA controller or a CPU.
- Responds only when the transaction address falls inside its window.
- All bus outputs are 0 whenever it is not driving, so they can be OR-combined with other slaves.

Parameters:
baseAddress, 32'h40000000, byte address of the first word; must be aligned to sizeInBytes.
sizeInBytes, 16*1024, memory size; power of two, at least 64.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
beginTransactionIn  in  1  start of a transaction; address, readNotWrite, byteEnables and burstSize are valid this cycle
endTransactionIn  in  1  transaction terminated by the master or arbiter
readNotWriteIn  in  1  1 = read, 0 = write
dataValidIn  in  1  write data word valid on addressDataIn
busyIn  in  1  master cannot accept the read word presented this cycle
addressDataIn  in  32  address in the begin cycle, write data otherwise
byteEnablesIn  in  4  byte lanes
burstSizeIn  in  8  number of words minus 1
beginTransactionOut  out  1  constant 0 (responder only)
readNotWriteOut  out  1  constant 0
byteEnablesOut  out  4  constant 0
burstSizeOut  out  8  constant 0
endTransactionOut  out  1  end of a read transaction
dataValidOut  out  1  read word valid
busErrorOut  out  1  transaction rejected
busyOut  out  1  constant 0; writes are always accepted
addressDataOut  out  32  read data; 0 when dataValidOut=0

Behaviour:
- Reset: state IDLE. All outputs 0. Memory contents are not cleared.
- Reset in any state aborts the current transaction in the next cycle; no endTransactionOut is issued.
- Sampling: bus inputs are registered. In the begin cycle, capture address, readNotWrite, byteEnables and burstSize.
- Hit: address[31:log2(sizeInBytes)] == baseAddress[31:log2(sizeInBytes)]. A miss is ignored and the block stays IDLE.
- Error conditions on a hit:
  - address[1:0] != 0;
  - burstSize != 0 while byteEnables != 4'hF;
  - word offset + burstSize beyond the last word (no wrap-around).
- On error: go to ERROR_WAIT and assert busErrorOut from the cycle after the begin cycle until endTransactionIn is seen.
  - busErrorOut drops in the cycle endTransactionIn is high.
  - No data is driven and no memory write occurs.
- States: IDLE, READ_FILL, READ_DATA, READ_END, WRITE_DATA, ERROR_WAIT.
- Read, begin cycle T:
  - READ_FILL issues the synchronous RAM read.
  - The first word appears on dataValidOut/addressDataOut in cycle T+2.
  - A word counts as accepted in a cycle with dataValidOut=1 and busyIn=0. The next word follows in the next cycle.
  - If busyIn=1, the same word and dataValidOut are held unchanged next cycle. Any number of consecutive busy cycles is allowed without losing or duplicating words; a one-entry skid register is permitted.
  - After burstSize+1 accepted words, READ_END drives endTransactionOut=1 for exactly one cycle, then IDLE.
  - A read always returns full 32-bit words regardless of byteEnables.
- Write:
  - WRITE_DATA writes each dataValidIn word at the current word address using the captured byteEnables; disabled lanes are untouched.
  - The address increments by one word per accepted word.
  - A write to word k is visible to a read begun at least 1 cycle after the last write data cycle.
  - More than burstSize+1 data words: the excess words are not written, and busErrorOut is asserted from the next cycle until endTransactionIn.
  - endTransactionIn returns the block to IDLE. Fewer words than announced is legal: the remaining words are simply not written.
- endTransactionIn during a read, before the last word is accepted: abort and go to IDLE next cycle with all outputs 0.
- Begin while not IDLE: not legal bus behaviour. The new begin is ignored until IDLE.
- Address counter width: log2(sizeInBytes)-2 bits.

Test Plan:
- Single write then read: write 0x12345678 to base+0x10 with BE=F, then read base+0x10 burst 0. Required: dataValidOut at T+2 carrying 0x12345678, then endTransactionOut for 1 cycle at T+3.
- Burst read with stalls: preload words 0..7 as 0xA0..0xA7, read base burst 7 with busyIn high on the 2nd and 5th valid cycles. Required: exactly 8 accepted words, in order 0xA0..0xA7, no duplicates, then a single endTransactionOut.
- Byte-enable write: word = 0xFFFFFFFF, write 0x00000000 with BE=4'b0101. Required: readback 0xFF00FF00.
- Errors:
  - address base+0x2 → busErrorOut held until endTransactionIn, memory unchanged;
  - burst 3 at the last word → error;
  - burst 1 with BE=3 → error.
- Miss and wired-OR: transaction to baseAddress+sizeInBytes. Required: all outputs stay 0 throughout.
- Reset mid-read-burst at word 3 of 8. Required: the next cycle has all outputs 0 and state IDLE; a following read returns the original data.

Source files
------------

// File: rtl/bus_burst_sram_slave.sv
// Word-organised SRAM responder on the shared burst bus: single/burst reads and writes
// inside an aligned address window; every output is 0 while idle so slaves can be OR-combined.
module bus_burst_sram_slave #(
    parameter logic [31:0] baseAddress = 32'h40000000,
    parameter int          sizeInBytes = 16 * 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        busyIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    output logic        beginTransactionOut,
    output logic        readNotWriteOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        endTransactionOut,
    output logic        dataValidOut,
    output logic        busErrorOut,
    output logic        busyOut,
    output logic [31:0] addressDataOut
);

    localparam int BW    = $clog2(sizeInBytes);
    localparam int AW    = BW - 2;
    localparam int WORDS = sizeInBytes / 4;

    typedef enum logic [2:0] {
        IDLE,
        READ_FILL,
        READ_DATA,
        READ_END,
        WRITE_DATA,
        ERROR_WAIT
    } state_t;

    state_t        state;
    logic [31:0]   mem [WORDS];
    logic [AW-1:0] addr_p0;
    logic [7:0]    remaining_p0;
    logic [3:0]    be_p0;
    logic          done_p0;
    logic          ovf_p0;
    logic          vld_p1;
    logic          end_p1;
    logic [31:0]   rdata_p1;

    logic          hit;
    logic          begin_err;
    logic [AW-1:0] begin_offset;
    logic [31:0]   span;
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] rd_idx;

    // Decode of the begin cycle, evaluated directly on the bus inputs
    assign hit          = addressDataIn[31:BW] == baseAddress[31:BW];
    assign begin_offset = addressDataIn[BW-1:2];
    assign span         = 32'(begin_offset) + 32'(burstSizeIn);
    assign begin_err    = (addressDataIn[1:0] != 2'b00)
                        || ((burstSizeIn != 8'd0) && (byteEnablesIn != 4'hF))
                        || (span > 32'(WORDS - 1));

    assign accept = (state == READ_DATA) && vld_p1 && !busyIn;
    assign wr_en  = (state == WRITE_DATA) && dataValidIn && !done_p0;

    // Re-reading the held word during busy keeps the output stable without a skid register
    always_comb begin
        rd_idx = addr_p0;
        if (accept) begin
            rd_idx = addr_p0 + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        rdata_p1 <= mem[rd_idx];
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be_p0[i]) begin
                    mem[addr_p0][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            vld_p1  <= 1'b0;
            end_p1  <= 1'b0;
            ovf_p0  <= 1'b0;
            done_p0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vld_p1  <= 1'b0;
                    end_p1  <= 1'b0;
                    ovf_p0  <= 1'b0;
                    done_p0 <= 1'b0;
                    if (beginTransactionIn && hit) begin
                        addr_p0      <= begin_offset;
                        remaining_p0 <= burstSizeIn;
                        be_p0        <= byteEnablesIn;
                        if (begin_err) begin
                            state <= ERROR_WAIT;
                        end else if (readNotWriteIn) begin
                            state <= READ_FILL;
                        end else begin
                            state <= WRITE_DATA;
                        end
                    end
                end
                READ_FILL: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else begin
                        state  <= READ_DATA;
                        vld_p1 <= 1'b1;
                    end
                end
                READ_DATA: begin
                    if (endTransactionIn) begin
                        state  <= IDLE;
                        vld_p1 <= 1'b0;
                    end else if (accept) begin
                        if (remaining_p0 == 8'd0) begin
                            state  <= READ_END;
                            vld_p1 <= 1'b0;
                            end_p1 <= 1'b1;
                        end else begin
                            remaining_p0 <= remaining_p0 - 8'd1;
                            addr_p0      <= addr_p0 + AW'(1);
                        end
                    end
                end
                READ_END: begin
                    end_p1 <= 1'b0;
                    state  <= IDLE;
                end
                WRITE_DATA: begin
                    if (dataValidIn) begin
                        if (done_p0) begin
                            ovf_p0 <= 1'b1;
                        end else if (remaining_p0 == 8'd0) begin
                            done_p0 <= 1'b1;
                        end else begin
                            remaining_p0 <= remaining_p0 - 8'd1;
                            addr_p0      <= addr_p0 + AW'(1);
                        end
                    end
                    if (endTransactionIn) begin
                        state  <= IDLE;
                        ovf_p0 <= 1'b0;
                    end
                end
                ERROR_WAIT: begin
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Error flag falls in the very cycle the master ends the transaction
    assign busErrorOut = ((state == ERROR_WAIT) || ovf_p0) && !endTransactionIn;

    assign beginTransactionOut = 1'b0;
    assign readNotWriteOut     = 1'b0;
    assign byteEnablesOut      = 4'h0;
    assign burstSizeOut        = 8'h00;
    assign busyOut             = 1'b0;
    assign endTransactionOut   = end_p1;
    assign dataValidOut        = vld_p1;
    assign addressDataOut      = vld_p1 ? rdata_p1 : 32'h0;

endmodule

// File: tb/tb_bus_burst_sram_slave.sv
// Directed bench for bus_burst_sram_slave: writes, stalled burst reads, byte lanes,
// error cases, address misses and reset during a read burst.
module tb_bus_burst_sram_slave;

    localparam logic [31:0] BASE = 32'h40000000;
    localparam int          SIZE = 16 * 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        beginTransactionIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        readNotWriteIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic        busyIn = 1'b0;
    logic [31:0] addressDataIn = 32'h0;
    logic [3:0]  byteEnablesIn = 4'h0;
    logic [7:0]  burstSizeIn = 8'h0;
    logic        beginTransactionOut;
    logic        readNotWriteOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        endTransactionOut;
    logic        dataValidOut;
    logic        busErrorOut;
    logic        busyOut;
    logic [31:0] addressDataOut;

    logic [49:0] all_out;
    logic [31:0] exp_q [16];
    logic [31:0] wr_q [8];
    int tests = 0;
    int fails = 0;

    bus_burst_sram_slave #(.baseAddress(BASE), .sizeInBytes(SIZE)) dut (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .busyIn(busyIn),
        .addressDataIn(addressDataIn), .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
        .beginTransactionOut(beginTransactionOut), .readNotWriteOut(readNotWriteOut),
        .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
        .endTransactionOut(endTransactionOut), .dataValidOut(dataValidOut),
        .busErrorOut(busErrorOut), .busyOut(busyOut), .addressDataOut(addressDataOut)
    );

    assign all_out = {beginTransactionOut, readNotWriteOut, byteEnablesOut, burstSizeOut,
                      endTransactionOut, dataValidOut, busErrorOut, busyOut, addressDataOut};

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be,
                             input logic [7:0] burst, input int n);
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b0;
        addressDataIn = a; byteEnablesIn = be; burstSizeIn = burst;
        tick();
        beginTransactionIn = 1'b0; byteEnablesIn = 4'h0; burstSizeIn = 8'h0;
        for (int i = 0; i < n; i++) begin
            dataValidIn = 1'b1; addressDataIn = wr_q[i];
            tick();
        end
        dataValidIn = 1'b0; addressDataIn = 32'h0; endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
    endtask

    // Reads burst+1 words, stalling on the valid cycles flagged in busy_mask
    task automatic bus_read(input logic [31:0] a, input logic [7:0] burst,
                            input logic [15:0] busy_mask, input string tag);
        int got = 0;
        int vcyc = 0;
        int ends = 0;
        int first_vld = -1;
        int end_cyc = -1;
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1;
        addressDataIn = a; byteEnablesIn = 4'hF; burstSizeIn = burst;
        tick();
        beginTransactionIn = 1'b0; readNotWriteIn = 1'b0;
        addressDataIn = 32'h0; byteEnablesIn = 4'h0; burstSizeIn = 8'h0;
        #1 check({tag, "_fill_quiet"}, 64'(all_out), 64'h0);
        for (int cyc = 0; cyc < 64; cyc++) begin
            tick();
            busyIn = dataValidOut && busy_mask[vcyc[3:0]];
            #1;
            if (dataValidOut) begin
                if (first_vld < 0) first_vld = cyc;
                check({tag, "_data"}, 64'(addressDataOut), 64'(exp_q[got[3:0]]));
                if (!busyIn) got++;
                vcyc++;
            end
            if (endTransactionOut) begin
                ends++;
                end_cyc = cyc;
                break;
            end
        end
        busyIn = 1'b0;
        check({tag, "_first_at_T+2"}, 64'(first_vld), 64'd0);
        check({tag, "_word_count"}, 64'(got), 64'(int'(burst) + 1));
        check({tag, "_end_seen"}, 64'(ends), 64'd1);
        check({tag, "_end_after_last"}, 64'(end_cyc), 64'(vcyc));
        tick();
        check({tag, "_end_single"}, 64'(all_out), 64'h0);
    endtask

    // Rejected transaction: error from T+1, dropped while endTransactionIn is high
    task automatic err_txn(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                           input logic [7:0] burst, input string tag);
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = rnw;
        addressDataIn = a; byteEnablesIn = be; burstSizeIn = burst;
        tick();
        beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; byteEnablesIn = 4'h0; burstSizeIn = 8'h0;
        addressDataIn = 32'hDEADBEEF; dataValidIn = !rnw;
        #1 check({tag, "_err_t1"}, 64'(busErrorOut), 64'd1);
        check({tag, "_no_data_t1"}, 64'(dataValidOut), 64'd0);
        tick();
        #1 check({tag, "_err_held"}, 64'(busErrorOut), 64'd1);
        tick();
        dataValidIn = 1'b0; addressDataIn = 32'h0; endTransactionIn = 1'b1;
        #1 check({tag, "_err_drop"}, 64'(busErrorOut), 64'd0);
        tick();
        endTransactionIn = 1'b0;
        #1 check({tag, "_idle_after"}, 64'(all_out), 64'h0);
    endtask

    initial begin
        int got;
        reset = 1'b1;
        tick(); tick(); tick();
        check("reset_outputs", 64'(all_out), 64'h0);
        reset = 1'b0;
        tick();
        check("post_reset_idle", 64'(all_out), 64'h0);

        // Single write then single read
        wr_q[0] = 32'h12345678;
        bus_write(BASE + 32'h10, 4'hF, 8'd0, 1);
        exp_q[0] = 32'h12345678;
        bus_read(BASE + 32'h10, 8'd0, 16'h0000, "single");

        // Preload 0xA0..0xA7 then stalled burst read
        for (int i = 0; i < 8; i++) wr_q[i] = 32'hA0 + 32'(i);
        bus_write(BASE, 4'hF, 8'd7, 8);
        for (int i = 0; i < 8; i++) exp_q[i] = 32'hA0 + 32'(i);
        bus_read(BASE, 8'd7, 16'b0000_0000_0001_0010, "burst_stall");

        // Byte-lane write
        wr_q[0] = 32'hFFFFFFFF;
        bus_write(BASE + 32'h20, 4'hF, 8'd0, 1);
        wr_q[0] = 32'h00000000;
        bus_write(BASE + 32'h20, 4'b0101, 8'd0, 1);
        exp_q[0] = 32'hFF00FF00;
        bus_read(BASE + 32'h20, 8'd0, 16'h0000, "byte_en");

        // Error cases; memory words 0 and 1 must keep their preload
        err_txn(BASE + 32'h2, 1'b0, 4'hF, 8'd0, "misaligned");
        err_txn(BASE + 32'(SIZE - 4), 1'b1, 4'hF, 8'd3, "past_end");
        err_txn(BASE, 1'b0, 4'h3, 8'd1, "burst_partial_be");
        exp_q[0] = 32'hA0; exp_q[1] = 32'hA1;
        bus_read(BASE, 8'd1, 16'h0000, "err_mem_kept");

        // Excess write data: second word dropped and flagged
        wr_q[0] = 32'h0A0A0A0A;
        bus_write(BASE + 32'h28, 4'hF, 8'd0, 1);
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b0;
        addressDataIn = BASE + 32'h24; byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
        tick();
        beginTransactionIn = 1'b0; dataValidIn = 1'b1; addressDataIn = 32'h11111111;
        #1 check("ovf_no_err_yet", 64'(busErrorOut), 64'd0);
        tick();
        addressDataIn = 32'h22222222;
        #1 check("ovf_no_err_last_ok", 64'(busErrorOut), 64'd0);
        tick();
        dataValidIn = 1'b0; addressDataIn = 32'h0;
        #1 check("ovf_err_set", 64'(busErrorOut), 64'd1);
        tick();
        #1 check("ovf_err_held", 64'(busErrorOut), 64'd1);
        endTransactionIn = 1'b1;
        #1 check("ovf_err_drop", 64'(busErrorOut), 64'd0);
        tick();
        endTransactionIn = 1'b0;
        exp_q[0] = 32'h11111111; exp_q[1] = 32'h0A0A0A0A;
        bus_read(BASE + 32'h24, 8'd1, 16'h0000, "ovf_readback");

        // Miss: just above the window, both read and write
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1;
        addressDataIn = BASE + 32'(SIZE); byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; addressDataIn = 32'h0;
            #1 check("miss_read_quiet", 64'(all_out), 64'h0);
        end
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b0;
        addressDataIn = BASE + 32'(SIZE); byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
        tick();
        beginTransactionIn = 1'b0; dataValidIn = 1'b1; addressDataIn = 32'h55555555;
        #1 check("miss_write_quiet", 64'(all_out), 64'h0);
        tick();
        dataValidIn = 1'b0; addressDataIn = 32'h0; endTransactionIn = 1'b1;
        #1 check("miss_end_quiet", 64'(all_out), 64'h0);
        tick();
        endTransactionIn = 1'b0;
        exp_q[0] = 32'hA0;
        bus_read(BASE, 8'd0, 16'h0000, "miss_mem_kept");

        // Reset while word 3 of an 8-word burst is on the bus
        tick();
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1;
        addressDataIn = BASE; byteEnablesIn = 4'hF; burstSizeIn = 8'd7;
        tick();
        beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; addressDataIn = 32'h0; burstSizeIn = 8'd0;
        got = 0;
        for (int c = 0; c < 32 && got < 3; c++) begin
            tick();
            if (dataValidOut) got++;
        end
        tick();
        check("rst_mid_word3", 64'(addressDataOut), 64'hA3);
        reset = 1'b1;
        tick();
        check("rst_mid_outputs", 64'(all_out), 64'h0);
        reset = 1'b0;
        tick();
        check("rst_mid_stays_idle", 64'(all_out), 64'h0);
        for (int i = 0; i < 8; i++) exp_q[i] = 32'hA0 + 32'(i);
        bus_read(BASE, 8'd7, 16'h0000, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
